calc_fsm_param: RTL and testbench
=================================

// Module: calc_fsm_param
// PURPOSE
//  Parametrised keypad calculator controller with a register bank: next generation of the 1-digit FSM.
//  Adds multi-digit decimal operand entry, configurable width and bank depth, and chaining (result -> A).
//  Adds overflow/error flags and single-accept-per-press key handshake. Sits between the keypad decoder
//  (ready/tecla) and the 7-seg display drivers (saidaA/saidaB/resultado).
// PARAMETERS
//  WIDTH     8   operand/result/register width, unsigned, modulo 2^WIDTH
//  NUM_REGS  10  register bank depth (1..10; addressed by one decimal digit)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  reset      in   1      synchronous, active-low reset
//  ready      in   1      key valid level from keypad decoder
//  tecla      in   8      key code: 0-9 digit, 10 '+', 11 '-', 12 STO, 13 RCL, 14 '=', 15 CLR; >15 ignored
//  saidaA     out  WIDTH  operand A
//  saidaB     out  WIDTH  operand B
//  resultado  out  WIDTH  last computed result
//  sinal      out  1      selected op: 0 add, 1 sub
//  igual      out  1      1 while result is displayed (state S_RES)
//  overflow   out  1      carry/borrow on last '=' or digit rejected for range
//  erro       out  1      last STO/RCL index >= NUM_REGS
// BEHAVIOUR
//  Reset (reset==0 at posedge): state S_A; all outputs 0; bank cleared; ready_q<=1; fresh<=1.
//   Reset wins over any key in the same cycle, also mid STO/RCL (no write occurs).
//  Handshake: key accepted only on cycle with ready & ~ready_q (rising edge); one key per press.
//   ready_q resets to 1, so a key held through reset release is not accepted. Outputs update 1 cycle after accept.
//  Digit entry: if fresh, operand<=d, fresh<=0; else operand<=operand*10+d computed WIDTH+4 bits;
//   if > 2^WIDTH-1, digit rejected, operand unchanged, overflow<=1.
//  States (enum in calc_pkg): S_A, S_B, S_RES, S_STO, S_RCL; field orig in {A,B,RES} records return target.
//  S_A: digit -> enter A; '+'/'-' -> sinal, B<=0, fresh<=1, S_B; STO -> orig=A, S_STO; RCL -> orig=A, S_RCL.
//  S_B: digit -> enter B; '+'/'-' -> update sinal only;
//   '=' -> resultado<=A+/-B mod 2^WIDTH, overflow<=carry (add) or A<B (sub), igual<=1, S_RES;
//   STO/RCL -> orig=B.
//  S_RES: digit -> A<=d, B<=0, igual<=0, overflow<=0, S_A (fresh<=0);
//   '+'/'-' -> chain: A<=resultado, B<=0, sinal set, igual<=0, S_B;
//   STO -> orig=RES; RCL -> orig=A, igual<=0, B<=0.
//  S_STO: digit d<NUM_REGS -> bank[d]<=value(orig), erro<=0, return to orig state; d>=NUM_REGS -> erro<=1, stay.
//  S_RCL: digit d<NUM_REGS -> operand(orig)<=bank[d], fresh<=1 (next digit replaces), erro<=0, return;
//   d>=NUM_REGS -> erro<=1, stay.
//  S_STO/S_RCL: CLR aborts with no write, back to orig. Other keys ignored.
//  CLR in S_A/S_B/S_RES: A,B,resultado,sinal,igual,overflow,erro <=0, fresh<=1, S_A; bank retained.
//  '=' in S_A ignored. Keys 10-14 while fresh in S_B act per table (B treated as 0).
//  Unused enum encodings -> S_A.
// STRUCTURE
//  calc_pkg: key code localparams (K_ADD..K_CLR), state_t enum, orig_t enum.
//  Sub-module calc_reg_bank #(WIDTH,NUM_REGS): 1 write port (we, waddr, wdata), 1 comb read port,
//   sync active-low clear.
//  Top: edge detector, FSM (sequential state + comb next-state), operand datapath, bank instance.
// TESTING
//  1 Reset held, ready=1 tecla=5, release reset -> no accept, saidaA=0; press again -> saidaA=5.
//  2 Keys 1,2,'+',3,4,'=' -> saidaA=12, saidaB=34, resultado=46, igual=1, overflow=0.
//  3 WIDTH=8: 2,5,5,6 -> saidaA=255, overflow=1; 3,'-',5,'=' -> resultado=254, overflow=1.
//  4 Chain: 7,'+',8,'=',STO,3,'-',5,'=' -> bank[3]=15, A=15 via chain, resultado=10.
//  5 NUM_REGS=4: STO,7 -> erro=1, stays S_STO; CLR -> back, no write; RCL,2 -> A=bank[2].
//  6 ready held 10 cycles on one digit -> accumulated once; reset mid S_STO -> no write, all 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state and return-target encodings for the keypad calculator.
package calc_pkg;

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] N_DIGITS = 4'd10;
  localparam logic [CODE_W-1:0] K_ADD    = 4'd10;
  localparam logic [CODE_W-1:0] K_SUB    = 4'd11;
  localparam logic [CODE_W-1:0] K_STO    = 4'd12;
  localparam logic [CODE_W-1:0] K_RCL    = 4'd13;
  localparam logic [CODE_W-1:0] K_EQ     = 4'd14;
  localparam logic [CODE_W-1:0] K_CLR    = 4'd15;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_RES = 3'd2,
    S_STO = 3'd3,
    S_RCL = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    O_A   = 2'd0,
    O_B   = 2'd1,
    O_RES = 2'd2
  } orig_t;

  // State to resume once a STO/RCL sequence completes or is aborted.
  function automatic state_t ret_state(input orig_t o);
    case (o)
      O_B:     return S_B;
      O_RES:   return S_RES;
      default: return S_A;
    endcase
  endfunction

endpackage

// File: rtl/calc_reg_bank.sv
// Register bank: one synchronous write port, one combinational read port, sync active-low clear.
module calc_reg_bank
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [CODE_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [CODE_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata_c
);

  logic [WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < int'(NUM_REGS); i++)
        if (i_waddr == CODE_W'(i)) r_mem[i] <= i_wdata;
    end
  end

  // Out-of-range addresses read as zero; callers range-check before use.
  always_comb begin
    o_rdata_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++)
      if (i_raddr == CODE_W'(i)) o_rdata_c = r_mem[i];
  end

endmodule

// File: rtl/calc_fsm_param.sv
// Keypad calculator controller: multi-digit decimal entry, add/sub with chaining,
// register bank store/recall, one accepted key per ready rising edge.
module calc_fsm_param
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [KEY_W-1:0] tecla,
  output logic [WIDTH-1:0] saidaA,
  output logic [WIDTH-1:0] saidaB,
  output logic [WIDTH-1:0] resultado,
  output logic             sinal,
  output logic             igual,
  output logic             overflow,
  output logic             erro
);

  localparam int unsigned       ACC_W     = WIDTH + 4;
  localparam logic [CODE_W-1:0] NREG_CODE = CODE_W'(NUM_REGS);

  state_t r_state, w_state_nxt;
  orig_t  r_orig,  w_orig_nxt;

  logic             r_ready_q, r_fresh, w_fresh_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_a_nxt, w_b_nxt, w_res_nxt;
  logic             r_sinal, r_igual, r_ovf, r_erro;
  logic             w_sinal_nxt, w_igual_nxt, w_ovf_nxt, w_erro_nxt;

  logic              w_key_ok, w_is_digit, w_is_op, w_sto, w_rcl, w_eq, w_clr, w_idx_ok, w_main;
  logic [CODE_W-1:0] w_code;
  logic [WIDTH-1:0]  w_ent_base, w_ent_val, w_store_val, w_rdata;
  logic [ACC_W-1:0]  w_acc;
  logic              w_acc_ovf, w_ent_rej, w_we;
  logic [WIDTH:0]    w_sum, w_diff;

  // Key decode: only the rising edge of ready carries a key; codes above 15 are ignored.
  assign w_code     = tecla[CODE_W-1:0];
  assign w_key_ok   = ready & ~r_ready_q & (tecla[KEY_W-1:CODE_W] == '0);
  assign w_is_digit = w_key_ok & (w_code < N_DIGITS);
  assign w_is_op    = w_key_ok & ((w_code == K_ADD) | (w_code == K_SUB));
  assign w_sto      = w_key_ok & (w_code == K_STO);
  assign w_rcl      = w_key_ok & (w_code == K_RCL);
  assign w_eq       = w_key_ok & (w_code == K_EQ);
  assign w_clr      = w_key_ok & (w_code == K_CLR);
  assign w_idx_ok   = w_code < NREG_CODE;
  assign w_main     = (r_state == S_A) | (r_state == S_B) | (r_state == S_RES);

  // Decimal accumulate in a wider field so an out-of-range digit can be rejected.
  assign w_ent_base = (r_state == S_B) ? r_b : r_a;
  assign w_acc      = (ACC_W'(w_ent_base) << 3) + (ACC_W'(w_ent_base) << 1) + ACC_W'(w_code);
  assign w_acc_ovf  = |w_acc[ACC_W-1:WIDTH];
  assign w_ent_rej  = ~r_fresh & w_acc_ovf;
  assign w_ent_val  = r_fresh ? WIDTH'(w_code) : (w_acc_ovf ? w_ent_base : w_acc[WIDTH-1:0]);

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  assign w_store_val = (r_orig == O_B) ? r_b : ((r_orig == O_RES) ? r_res : r_a);

  calc_reg_bank #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk       (clk),
    .rst_n     (reset),
    .i_we      (w_we),
    .i_waddr   (w_code),
    .i_wdata   (w_store_val),
    .i_raddr   (w_code),
    .o_rdata_c (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_A;
      r_orig  <= O_A;
    end else begin
      r_state <= w_state_nxt;
      r_orig  <= w_orig_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_orig_nxt  = r_orig;
    case (r_state)
      S_A: begin
        if (w_is_op)  w_state_nxt = S_B;
        else if (w_sto) begin w_orig_nxt = O_A; w_state_nxt = S_STO; end
        else if (w_rcl) begin w_orig_nxt = O_A; w_state_nxt = S_RCL; end
      end
      S_B: begin
        if (w_eq)       w_state_nxt = S_RES;
        else if (w_sto) begin w_orig_nxt = O_B; w_state_nxt = S_STO; end
        else if (w_rcl) begin w_orig_nxt = O_B; w_state_nxt = S_RCL; end
      end
      S_RES: begin
        if (w_is_digit)   w_state_nxt = S_A;
        else if (w_is_op) w_state_nxt = S_B;
        else if (w_sto)   begin w_orig_nxt = O_RES; w_state_nxt = S_STO; end
        else if (w_rcl)   begin w_orig_nxt = O_A;   w_state_nxt = S_RCL; end
      end
      S_STO, S_RCL: begin
        if ((w_is_digit & w_idx_ok) | w_clr) w_state_nxt = ret_state(r_orig);
      end
      default: w_state_nxt = S_A;
    endcase
    if (w_clr & w_main) w_state_nxt = S_A;
  end

  always_comb begin
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_res_nxt   = r_res;
    w_sinal_nxt = r_sinal;
    w_igual_nxt = r_igual;
    w_ovf_nxt   = r_ovf;
    w_erro_nxt  = r_erro;
    w_fresh_nxt = r_fresh;
    w_we        = 1'b0;
    case (r_state)
      S_A: begin
        if (w_is_digit) begin
          w_a_nxt     = w_ent_val;
          w_fresh_nxt = 1'b0;
          if (w_ent_rej) w_ovf_nxt = 1'b1;
        end else if (w_is_op) begin
          w_sinal_nxt = (w_code == K_SUB);
          w_b_nxt     = '0;
          w_fresh_nxt = 1'b1;
        end
      end
      S_B: begin
        if (w_is_digit) begin
          w_b_nxt     = w_ent_val;
          w_fresh_nxt = 1'b0;
          if (w_ent_rej) w_ovf_nxt = 1'b1;
        end else if (w_is_op) begin
          w_sinal_nxt = (w_code == K_SUB);
        end else if (w_eq) begin
          w_res_nxt   = r_sinal ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
          w_ovf_nxt   = r_sinal ? w_diff[WIDTH] : w_sum[WIDTH];
          w_igual_nxt = 1'b1;
        end
      end
      S_RES: begin
        if (w_is_digit) begin
          w_a_nxt     = WIDTH'(w_code);
          w_b_nxt     = '0;
          w_igual_nxt = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_fresh_nxt = 1'b0;
        end else if (w_is_op) begin
          w_a_nxt     = r_res;
          w_b_nxt     = '0;
          w_sinal_nxt = (w_code == K_SUB);
          w_igual_nxt = 1'b0;
          w_fresh_nxt = 1'b1;
        end else if (w_rcl) begin
          w_igual_nxt = 1'b0;
          w_b_nxt     = '0;
        end
      end
      S_STO: begin
        if (w_is_digit) begin
          w_we       = w_idx_ok;
          w_erro_nxt = ~w_idx_ok;
        end
      end
      S_RCL: begin
        if (w_is_digit) begin
          w_erro_nxt = ~w_idx_ok;
          if (w_idx_ok) begin
            if (r_orig == O_B) w_b_nxt = w_rdata;
            else               w_a_nxt = w_rdata;
            w_fresh_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // CLR wipes the working registers but keeps the bank contents.
    if (w_clr & w_main) begin
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_res_nxt   = '0;
      w_sinal_nxt = 1'b0;
      w_igual_nxt = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_erro_nxt  = 1'b0;
      w_fresh_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ready_q <= 1'b1;
      r_fresh   <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_sinal   <= 1'b0;
      r_igual   <= 1'b0;
      r_ovf     <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_ready_q <= ready;
      r_fresh   <= w_fresh_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_res     <= w_res_nxt;
      r_sinal   <= w_sinal_nxt;
      r_igual   <= w_igual_nxt;
      r_ovf     <= w_ovf_nxt;
      r_erro    <= w_erro_nxt;
    end
  end

  assign saidaA    = r_a;
  assign saidaB    = r_b;
  assign resultado = r_res;
  assign sinal     = r_sinal;
  assign igual     = r_igual;
  assign overflow  = r_ovf;
  assign erro      = r_erro;

endmodule

// File: tb/tb_calc_fsm_param.sv
// Bench for calc_fsm_param: directed scenarios plus random key streams against a calculator model.
module tb_calc_fsm_param;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int          MAXV     = 255;
  localparam int MA = 0, MB = 1, MR = 2, MS = 3, MC = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ready = 1'b0;
  logic [7:0]       tecla = 8'd0;
  logic [WIDTH-1:0] saidaA, saidaB, resultado;
  logic             sinal, igual, overflow, erro;
  logic [27:0]      obs;

  calc_fsm_param #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset), .ready(ready), .tecla(tecla),
    .saidaA(saidaA), .saidaB(saidaB), .resultado(resultado),
    .sinal(sinal), .igual(igual), .overflow(overflow), .erro(erro)
  );

  always #5 clk = ~clk;

  assign obs = {saidaA, saidaB, resultado, sinal, igual, overflow, erro};

  int n_vec  = 0;
  int n_miss = 0;

  // Calculator model: plain integers, a mode number and a return mode.
  int m_a, m_b, m_res, m_mode, m_orig;
  bit m_sin, m_ig, m_ovf, m_err, m_fresh;
  int bank [10];

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_mode = MA; m_orig = MA;
    m_sin = 0; m_ig = 0; m_ovf = 0; m_err = 0; m_fresh = 1;
    foreach (bank[i]) bank[i] = 0;
  endfunction

  function automatic void model_clear();
    m_a = 0; m_b = 0; m_res = 0; m_sin = 0; m_ig = 0; m_ovf = 0; m_err = 0;
    m_fresh = 1; m_mode = MA;
  endfunction

  function automatic int enter(input int v, input int d);
    if (m_fresh) begin m_fresh = 0; return d; end
    if (v * 10 + d > MAXV) begin m_ovf = 1; return v; end
    return v * 10 + d;
  endfunction

  function automatic void model_key(input int k);
    bit dig = (k < 10);
    if (k > 15) return;
    case (m_mode)
      MA: begin
        if (dig) m_a = enter(m_a, k);
        else if (k == 10 || k == 11) begin m_sin = (k == 11); m_b = 0; m_fresh = 1; m_mode = MB; end
        else if (k == 12) begin m_orig = MA; m_mode = MS; end
        else if (k == 13) begin m_orig = MA; m_mode = MC; end
        else if (k == 15) model_clear();
      end
      MB: begin
        if (dig) m_b = enter(m_b, k);
        else if (k == 10 || k == 11) m_sin = (k == 11);
        else if (k == 14) begin
          if (!m_sin) begin m_ovf = (m_a + m_b > MAXV); m_res = (m_a + m_b) % 256; end
          else begin m_ovf = (m_a < m_b); m_res = (m_a - m_b + 256) % 256; end
          m_ig = 1; m_mode = MR;
        end
        else if (k == 12) begin m_orig = MB; m_mode = MS; end
        else if (k == 13) begin m_orig = MB; m_mode = MC; end
        else if (k == 15) model_clear();
      end
      MR: begin
        if (dig) begin m_a = k; m_b = 0; m_ig = 0; m_ovf = 0; m_fresh = 0; m_mode = MA; end
        else if (k == 10 || k == 11) begin
          m_a = m_res; m_b = 0; m_sin = (k == 11); m_ig = 0; m_fresh = 1; m_mode = MB;
        end
        else if (k == 12) begin m_orig = MR; m_mode = MS; end
        else if (k == 13) begin m_orig = MA; m_ig = 0; m_b = 0; m_mode = MC; end
        else if (k == 15) model_clear();
      end
      MS: begin
        if (dig && k < NUM_REGS) begin
          bank[k] = (m_orig == MB) ? m_b : ((m_orig == MR) ? m_res : m_a);
          m_err = 0; m_mode = m_orig;
        end else if (dig) m_err = 1;
        else if (k == 15) m_mode = m_orig;
      end
      default: begin
        if (dig && k < NUM_REGS) begin
          if (m_orig == MB) m_b = bank[k]; else m_a = bank[k];
          m_fresh = 1; m_err = 0; m_mode = m_orig;
        end else if (dig) m_err = 1;
        else if (k == 15) m_mode = m_orig;
      end
    endcase
  endfunction

  function automatic logic [27:0] exp_vec();
    return {8'(m_a), 8'(m_b), 8'(m_res), m_sin, m_ig, m_ovf, m_err};
  endfunction

  // One press: ready high for one cycle, then low; leaves us at a negedge after the accept.
  task automatic press(input int k);
    @(negedge clk);
    ready = 1'b1;
    tecla = 8'(k);
    @(negedge clk);
    ready = 1'b0;
    model_key(k);
  endtask

  task automatic test_reset();
    reset = 1'b0; ready = 1'b1; tecla = 8'd5;
    repeat (3) @(negedge clk);
    model_reset();
    n_vec++;
    if (obs !== exp_vec()) begin n_miss++; $display("FAIL reset_state got=%h exp=%h", obs, exp_vec()); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (saidaA !== 8'd0) begin n_miss++; $display("FAIL held_key_after_reset got=%0d exp=0", saidaA); end
    ready = 1'b0;
    press(5);
    n_vec++;
    if (saidaA !== 8'd5) begin n_miss++; $display("FAIL first_press got=%0d exp=5", saidaA); end
  endtask

  task automatic test_basic();
    int seq[$] = '{15, 1, 2, 10, 3, 4, 14};
    foreach (seq[i]) begin
      press(seq[i]);
      n_vec++;
      if (obs !== exp_vec()) begin n_miss++; $display("FAIL basic key=%0d got=%h exp=%h", seq[i], obs, exp_vec()); end
    end
    n_vec++;
    if ({saidaA, saidaB, resultado, igual, overflow} !== {8'd12, 8'd34, 8'd46, 1'b1, 1'b0}) begin
      n_miss++; $display("FAIL basic_sum got A=%0d B=%0d R=%0d ig=%b ov=%b exp 12 34 46 1 0",
                        saidaA, saidaB, resultado, igual, overflow);
    end
  endtask

  task automatic test_overflow();
    int seq[$] = '{15, 2, 5, 5, 6};
    foreach (seq[i]) press(seq[i]);
    n_vec++;
    if ({saidaA, overflow} !== {8'd255, 1'b1}) begin
      n_miss++; $display("FAIL digit_range got A=%0d ov=%b exp A=255 ov=1", saidaA, overflow);
    end
    seq = '{15, 3, 11, 5, 14};
    foreach (seq[i]) press(seq[i]);
    n_vec++;
    if ({resultado, overflow, igual} !== {8'd254, 1'b1, 1'b1}) begin
      n_miss++; $display("FAIL sub_borrow got R=%0d ov=%b ig=%b exp R=254 ov=1 ig=1", resultado, overflow, igual);
    end
    n_vec++;
    if (obs !== exp_vec()) begin n_miss++; $display("FAIL overflow_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_chain();
    int seq[$] = '{15, 7, 10, 8, 14, 12, 3, 11, 5, 14};
    foreach (seq[i]) begin
      press(seq[i]);
      n_vec++;
      if (obs !== exp_vec()) begin n_miss++; $display("FAIL chain key=%0d got=%h exp=%h", seq[i], obs, exp_vec()); end
    end
    n_vec++;
    if ({saidaA, resultado, sinal} !== {8'd15, 8'd10, 1'b1}) begin
      n_miss++; $display("FAIL chain_result got A=%0d R=%0d s=%b exp A=15 R=10 s=1", saidaA, resultado, sinal);
    end
    press(13); press(3);
    n_vec++;
    if ({saidaA, igual, erro} !== {8'd15, 1'b0, 1'b0}) begin
      n_miss++; $display("FAIL recall_bank3 got A=%0d ig=%b er=%b exp A=15 ig=0 er=0", saidaA, igual, erro);
    end
  endtask

  task automatic test_regs();
    int seq[$] = '{15, 9, 9, 12, 2, 15, 12, 7};
    foreach (seq[i]) press(seq[i]);
    n_vec++;
    if (erro !== 1'b1) begin n_miss++; $display("FAIL sto_range got erro=%b exp=1", erro); end
    seq = '{15, 15, 13, 2};
    foreach (seq[i]) press(seq[i]);
    n_vec++;
    if ({saidaA, erro} !== {8'd99, 1'b0}) begin
      n_miss++; $display("FAIL rcl_bank2 got A=%0d er=%b exp A=99 er=0", saidaA, erro);
    end
    seq = '{13, 5};
    foreach (seq[i]) press(seq[i]);
    n_vec++;
    if ({saidaA, erro} !== {8'd99, 1'b1}) begin
      n_miss++; $display("FAIL rcl_range got A=%0d er=%b exp A=99 er=1", saidaA, erro);
    end
    press(15);
    n_vec++;
    if (obs !== exp_vec()) begin n_miss++; $display("FAIL regs_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_hold();
    press(15);
    @(negedge clk);
    ready = 1'b1; tecla = 8'd4;
    repeat (10) @(negedge clk);
    ready = 1'b0;
    model_key(4);
    n_vec++;
    if (saidaA !== 8'd4) begin n_miss++; $display("FAIL held_once got A=%0d exp=4", saidaA); end
    press(4);
    n_vec++;
    if (saidaA !== 8'd44) begin n_miss++; $display("FAIL second_press got A=%0d exp=44", saidaA); end
  endtask

  task automatic test_reset_mid();
    press(1); press(2); press(12);
    @(negedge clk);
    reset = 1'b0; ready = 1'b1; tecla = 8'd1;
    @(negedge clk);
    reset = 1'b1; ready = 1'b0;
    @(negedge clk);
    model_reset();
    n_vec++;
    if (obs !== 28'd0) begin n_miss++; $display("FAIL reset_mid_sto got=%h exp=0", obs); end
    press(13); press(1);
    n_vec++;
    if ({saidaA, erro} !== {8'd0, 1'b0}) begin
      n_miss++; $display("FAIL no_write_after_reset got A=%0d er=%b exp A=0 er=0", saidaA, erro);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      int k = int'($urandom_range(0, 19));
      if (k >= 16) k = (k == 19) ? 200 : k;
      press(k);
      n_vec++;
      if (obs !== exp_vec()) begin n_miss++; $display("FAIL random n=%0d key=%0d got=%h exp=%h", n, k, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_chain();
    test_regs();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
